// File: rtl/stream_demux.sv
// stream_demux: routes one WIDTH-bit valid/ready stream to one of CHANNELS
// output streams, chosen per beat by `select`. Each output channel has a
// one-entry holding register, so a stalled consumer only blocks beats that
// are addressed to it. A select value that names no channel is accepted,
// discarded and reported on `dropPulse` one cycle later.
//
// Optional feature: define STREAM_DEMUX_BCAST_EN to add the `bcast` input.
// A broadcast beat ignores `select`, waits until every channel can take it,
// and then loads all channels at once.

module stream_demux #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [WIDTH-1:0]          in,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [SELW-1:0]           select,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                      bcast,
`endif
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       outValid,
    input  logic [CHANNELS-1:0]       outReady,
    output logic                      dropPulse
);

    // Per-channel holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e               state      [CHANNELS];
    chan_state_e               state_next [CHANNELS];

    logic [CHANNELS-1:0]       sel_hot;
    logic [CHANNELS-1:0]       stalled;
    logic [CHANNELS-1:0]       load_mask;
    logic [CHANNELS-1:0]       load;
    logic                      sel_legal;
    logic                      bcast_beat;
    logic                      accept;
    logic                      drop_next;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast_beat = bcast;
`else
    assign bcast_beat = 1'b0;
`endif

    // Decode select into a one-hot channel vector; an out-of-range select
    // matches no channel, which is how illegal beats are recognised.
    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (select == SELW'(k)) begin
                sel_hot[k] = 1'b1;
            end
        end
        sel_legal = |sel_hot;
    end

    // Ready only depends on whether the targeted channel(s) can take a beat
    // this cycle; a full channel whose consumer is taking its beat counts
    // as free so each channel sustains one beat per cycle.
    always_comb begin
        stalled   = outValid & ~outReady;
        load_mask = '0;
        inReady   = 1'b1;
        if (bcast_beat) begin
            load_mask = '1;
            inReady   = ~|stalled;
        end else begin
            load_mask = sel_hot;
            inReady   = ~|(stalled & sel_hot);
        end
    end

    // Handshake outcome: which channels load and whether a beat is dropped.
    always_comb begin
        accept    = inValid & inReady;
        load      = accept ? load_mask : '0;
        drop_next = accept & ~bcast_beat & ~sel_legal;
    end

    // Channel occupancy registers; reset empties every channel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state[k] <= EMPTY;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                state[k] <= state_next[k];
            end
        end
    end

    // Next occupancy: a load always leaves the channel full (this covers the
    // drain-and-reload case), otherwise a consumed beat empties it.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            state_next[k] = state[k];
            case (state[k])
                EMPTY: begin
                    if (load[k]) begin
                        state_next[k] = FULL;
                    end
                end
                FULL: begin
                    if (load[k]) begin
                        state_next[k] = FULL;
                    end else if (outReady[k]) begin
                        state_next[k] = EMPTY;
                    end
                end
                default: begin
                    state_next[k] = EMPTY;
                end
            endcase
        end
    end

    // Expose occupancy as the per-channel valid flags.
    always_comb begin
        outValid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            outValid[k] = (state[k] == FULL);
        end
    end

    // Channel data registers: only written on a load, so data stays stable
    // while a channel is stalled and keeps its last value after draining.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    out[k*WIDTH +: WIDTH] <= in;
                end
            end
        end
    end

    // One-cycle indication that the previous accepted beat had no destination.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dropPulse <= 1'b0;
        end else begin
            dropPulse <= drop_next;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: a 4-channel instance (A) and a 3-channel
// instance (B, where select value 3 is illegal) run side by side against a
// queue-free behavioural model of each channel's holding slot.

module tb_stream_demux;

    logic        clk;
    logic        resetN;

    logic [15:0] inA;
    logic        validA;
    logic        inReadyA;
    logic [1:0]  selA;
    logic [63:0] outA;
    logic [3:0]  outValidA;
    logic [3:0]  ordyA;
    logic        dropA;
    logic        bcA;

    logic [15:0] inB;
    logic        validB;
    logic        inReadyB;
    logic [1:0]  selB;
    logic [47:0] outB;
    logic [2:0]  outValidB;
    logic [2:0]  ordyB;
    logic        dropB;
    logic        bcB;

    int          vectors;
    int          miscompares;

    bit          mvalid [2][4];
    logic [15:0] mdata  [2][4];
    bit          mdrop  [2];

    stream_demux #(.WIDTH(16), .CHANNELS(4)) dutA (
        .clk       (clk),
        .resetN    (resetN),
        .in        (inA),
        .inValid   (validA),
        .inReady   (inReadyA),
        .select    (selA),
`ifdef STREAM_DEMUX_BCAST_EN
        .bcast     (bcA),
`endif
        .out       (outA),
        .outValid  (outValidA),
        .outReady  (ordyA),
        .dropPulse (dropA)
    );

    stream_demux #(.WIDTH(16), .CHANNELS(3)) dutB (
        .clk       (clk),
        .resetN    (resetN),
        .in        (inB),
        .inValid   (validB),
        .inReady   (inReadyB),
        .select    (selB),
`ifdef STREAM_DEMUX_BCAST_EN
        .bcast     (bcB),
`endif
        .out       (outB),
        .outValid  (outValidB),
        .outReady  (ordyB),
        .dropPulse (dropB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Can the block take a beat right now, from the slot occupancy rules.
    function automatic bit expReady(input int d, input int sel, input logic [3:0] ordy, input bit bc);
        if (bc) begin
            for (int k = 0; k < nch(d); k++) begin
                if (mvalid[d][k] && !ordy[k]) return 1'b0;
            end
            return 1'b1;
        end
        if (sel >= nch(d)) return 1'b1;
        return !mvalid[d][sel] || ordy[sel];
    endfunction

    // Advance one instance's slots by one clock edge.
    task automatic modelEdge(input int d, input bit v, input int sel, input logic [15:0] data,
                             input logic [3:0] ordy, input bit bc);
        bit acc;
        acc = v && expReady(d, sel, ordy, bc);
        for (int k = 0; k < nch(d); k++) begin
            if (acc && (bc || sel == k)) begin
                mvalid[d][k] = 1'b1;
                mdata[d][k]  = data;
            end else if (mvalid[d][k] && ordy[k]) begin
                mvalid[d][k] = 1'b0;
            end
        end
        mdrop[d] = acc && !bc && (sel >= nch(d));
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mvalid[d][k] = 1'b0;
                mdata[d][k]  = '0;
            end
            mdrop[d] = 1'b0;
        end
    endtask

    task automatic checkAll();
        logic [3:0] ev;
        ev = '0;
        for (int k = 0; k < 4; k++) ev[k] = mvalid[0][k];
        checkOutput("readyA", inReadyA, expReady(0, selA, ordyA, bcA));
        checkOutput("validA", outValidA, ev);
        checkOutput("dropA", dropA, mdrop[0]);
        for (int k = 0; k < 4; k++) begin
            if (mvalid[0][k]) checkOutput($sformatf("dataA%0d", k), outA[k*16 +: 16], mdata[0][k]);
        end
        ev = '0;
        for (int k = 0; k < 3; k++) ev[k] = mvalid[1][k];
        checkOutput("readyB", inReadyB, expReady(1, selB, {1'b0, ordyB}, bcB));
        checkOutput("validB", outValidB, ev[2:0]);
        checkOutput("dropB", dropB, mdrop[1]);
        for (int k = 0; k < 3; k++) begin
            if (mvalid[1][k]) checkOutput($sformatf("dataB%0d", k), outB[k*16 +: 16], mdata[1][k]);
        end
    endtask

    // One clock: check settled outputs, step the model at the edge, return at negedge.
    task automatic applyStimulus();
        #1;
        checkAll();
        @(posedge clk);
        if (resetN) begin
            modelEdge(0, validA, selA, inA, ordyA, bcA);
            modelEdge(1, validB, selB, inB, {1'b0, ordyB}, bcB);
        end
        @(negedge clk);
    endtask

    task automatic idleAll(input logic [3:0] ordy);
        validA = 1'b0; validB = 1'b0; bcA = 1'b0; bcB = 1'b0;
        ordyA = ordy; ordyB = ordy[2:0];
    endtask

    initial begin
        logic [2:0] vB;
        vectors = 0;
        miscompares = 0;
        resetN = 1'b0;
        inA = '0; selA = '0; inB = '0; selB = '0;
        idleAll(4'h0);
        modelReset();

        #1;
        checkOutput("rst_validA", outValidA, 4'h0);
        checkOutput("rst_outA", outA, 64'h0);
        checkOutput("rst_drop", dropA, 1'b0);
        applyStimulus();
        applyStimulus();
        resetN = 1'b1;
        applyStimulus();

        // Reset mid-stream with two channels holding data.
        validA = 1'b1; selA = 2'd0; inA = 16'h1234;
        applyStimulus();
        selA = 2'd2; inA = 16'hBEEF;
        applyStimulus();
        validA = 1'b0;
        checkOutput("mid_validA", outValidA, 4'b0101);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrst_validA", outValidA, 4'h0);
        checkOutput("midrst_outA", outA, 64'h0);
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
        validA = 1'b1; selA = 2'd1; inA = 16'h0001;
        applyStimulus();
        validA = 1'b0;
        checkOutput("rel_validA", outValidA, 4'b0010);
        checkOutput("rel_data1", outA[31:16], 16'h0001);

        // Full throughput on channel 3.
        idleAll(4'hF);
        applyStimulus();
        for (int i = 0; i < 8; i++) begin
            validA = 1'b1; selA = 2'd3; inA = 16'(i);
            #1;
            checkOutput("thru_ready", inReadyA, 1'b1);
            applyStimulus();
            checkOutput("thru_data", outA[63:48], 64'(i));
        end
        validA = 1'b0;
        applyStimulus();

        // Backpressure isolation on channel 1.
        idleAll(4'hF);
        applyStimulus();
        ordyA = 4'h0;
        validA = 1'b1; selA = 2'd1; inA = 16'hAAAA;
        applyStimulus();
        inA = 16'h1234;
        #1;
        checkOutput("bp_ready", inReadyA, 1'b0);
        applyStimulus();
        checkOutput("bp_hold", outA[31:16], 16'hAAAA);
        selA = 2'd2; inA = 16'h5555;
        applyStimulus();
        validA = 1'b0;
        checkOutput("bp_other", outValidA[2], 1'b1);
        checkOutput("bp_other_data", outA[47:32], 16'h5555);

        // Drain and reload in the same cycle on channel 0.
        idleAll(4'hF);
        applyStimulus();
        ordyA = 4'h0;
        validA = 1'b1; selA = 2'd0; inA = 16'h1111;
        applyStimulus();
        ordyA = 4'b0001; inA = 16'h2222;
        applyStimulus();
        validA = 1'b0; ordyA = 4'h0;
        checkOutput("reload_valid", outValidA[0], 1'b1);
        checkOutput("reload_data", outA[15:0], 16'h2222);

        // Illegal select on the 3-channel instance.
        idleAll(4'h0);
        applyStimulus();
        vB = outValidB;
        validB = 1'b1; selB = 2'd3; inB = 16'h7777;
        #1;
        checkOutput("ill_ready", inReadyB, 1'b1);
        applyStimulus();
        validB = 1'b0;
        checkOutput("ill_drop", dropB, 1'b1);
        checkOutput("ill_valid", outValidB, vB);
        applyStimulus();
        checkOutput("ill_drop_end", dropB, 1'b0);

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast waits for every channel, then fills all of them.
        idleAll(4'hF);
        applyStimulus();
        ordyA = 4'h0;
        validA = 1'b1; selA = 2'd2; inA = 16'h1111;
        applyStimulus();
        bcA = 1'b1; inA = 16'hCAFE; selA = 2'd1;
        #1;
        checkOutput("bc_ready", inReadyA, 1'b0);
        applyStimulus();
        ordyA = 4'b0100;
        applyStimulus();
        validA = 1'b0; bcA = 1'b0; ordyA = 4'h0;
        checkOutput("bc_valid", outValidA, 4'hF);
        checkOutput("bc_data", outA, {4{16'hCAFE}});
        checkOutput("bc_drop", dropA, 1'b0);
`endif

        // Randomised traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            validA = 1'($urandom_range(0, 3) != 0);
            selA   = 2'($urandom_range(0, 3));
            inA    = 16'($urandom);
            ordyA  = 4'($urandom);
            validB = 1'($urandom_range(0, 3) != 0);
            selB   = 2'($urandom_range(0, 3));
            inB    = 16'($urandom);
            ordyB  = 3'($urandom);
`ifdef STREAM_DEMUX_BCAST_EN
            bcA = 1'($urandom_range(0, 7) == 0);
            bcB = 1'($urandom_range(0, 7) == 0);
`endif
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
